regsel_issue_stage: RTL and testbench
=====================================

// Module: regsel_issue_stage
// PURPOSE
//  Registered successor to the combinational read-select decoder. Decodes each
//  instruction into operand read selects, destination and class. Tracks pending
//  writes in a scoreboard and stalls on RAW/WAW hazards. Sits between fetch and
//  the register file/execute stage, with valid/ready handshakes on both sides.
// PARAMETERS
//  INSTR_W  32  instruction width; opcode is [INSTR_W-1 -: OPC_W]
//  OPC_W    6   opcode width
//  RA_W     5   register address width; NREG = 2**RA_W, r0 never busy
//  CNT_W    16  stall counter width
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       fetch presents in_instr
//  in_ready   out  1       stage accepts in_instr this cycle
//  in_instr   in   INSTR_W instruction: opc | A=[25:21] | B=[20:16] | C=[15:11]
//  flush      in   1       discard held output instruction
//  out_valid  out  1       decoded instruction held
//  out_ready  in   1       execute takes held instruction
//  out_instr  out  INSTR_W held instruction
//  out_rsel1  out  RA_W    read select port 1
//  out_rsel2  out  RA_W    read select port 2
//  out_rd     out  RA_W    destination register
//  out_rd_we  out  1       instruction writes out_rd
//  out_class  out  2       0=R, 1=BR, 2=I-ALU, 3=MEM
//  wb_valid   in   1       writeback retires a write to wb_addr
//  wb_addr    in   RA_W    register being written back
//  busy_vec   out  NREG    scoreboard, bit i = write to ri pending
//  stall_cnt  out  CNT_W   cycles in_valid was blocked by a hazard, saturating
// BEHAVIOUR
//  Reset: out_valid, out_instr, out_rsel1/2, out_rd, out_rd_we, out_class,
//   busy_vec and stall_cnt all 0. Async assert; release is sampled at clk.
//  Decode is on opcode o:
//   o[5:4]=01: R. rs1=B, rs2=C, rd=A, we=1.
//   o[5:4]=10: BR. rs1=A, rs2=B, we=0, rd=0.
//   o[5:3]=110: I-ALU. rs1=B, rs2=0 (unused), rd=A, we=1.
//   o[5:3]=111: MEM. o[0]=0 is a load: rs1=B, rd=A, we=1. o[0]=1 is a store:
//    rs1=B, rs2=A, we=0.
//   o[5:4]=00: NOP class R, rs1=rs2=rd=0, we=0.
//  Only sources actually used are hazard-checked. r0 never hazards.
//  hazard = used src or (we && rd) hits a busy bit, or the held entry's rd when
//   out_valid && out_rd_we. A wb_valid hit on the same register clears it
//   combinationally: wb bypasses the hazard and the instruction is accepted.
//  in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  Accept (in_valid & in_ready): decoded fields are registered and out_valid=1
//   on the next edge. Latency is 1 cycle, full throughput with no hazards.
//  Issue (out_valid & out_ready & !flush) sets busy[out_rd] if out_rd_we and
//   out_rd!=0. With no new accept, out_valid drops next cycle.
//  wb_valid clears busy[wb_addr]. If issue sets the same register in the same
//   cycle, the set wins.
//  flush: out_valid=0 next cycle, the held entry is not issued, busy_vec is
//   unchanged, and no accept happens that cycle.
//  stall_cnt increments each cycle in_valid & hazard, saturating at all-ones.
//   It clears only on reset.
//  out_* hold their values while out_valid & !out_ready. Data is stable under
//   backpressure.
//  Reset mid-stall or mid-hold drops everything immediately (async).
// TESTING
//  1 Reset asserted with in_valid=1 -> all outputs 0, in_ready=0 during reset.
//  2 R 010010_00011_00000_00001_0..0 accepted -> next cycle out_valid=1,
//    rsel1=0, rsel2=1, rd=3, we=1, class=0.
//  3 BR 100000_00001_00010_... -> rsel1=1, rsel2=2, we=0, class=1. Hold
//    out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//  4 I-ALU 110011_00001_00010 issued (busy_vec[1]=1), then R reading r1 ->
//    in_ready=0 and stall_cnt +1/cycle. wb_valid with wb_addr=1 -> accepted
//    that cycle and busy_vec[1]=0.
//  5 Store 111011_00001_00010 -> rsel1=2, rsel2=1, we=0. Load 111010 same
//    fields -> rsel1=2, rd=1, we=1.
//  6 flush while out_valid=1 and out_ready=0 -> out_valid=0 next cycle,
//    busy_vec unchanged. Issue and wb to the same register in one cycle ->
//    bit stays set.

Source files
------------

// File: rtl/regsel_issue_stage.sv
// rtl/regsel_issue_stage.sv - registered decode/issue stage with write scoreboard and RAW/WAW stall
module regsel_issue_stage #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [RA_W-1:0]    out_rsel1,
  output logic [RA_W-1:0]    out_rsel2,
  output logic [RA_W-1:0]    out_rd,
  output logic               out_rd_we,
  output logic [1:0]         out_class,
  input  logic               wb_valid,
  input  logic [RA_W-1:0]    wb_addr,
  output logic [(1<<RA_W)-1:0] busy_vec,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int NREG = 1 << RA_W;
  localparam logic [NREG-1:0] ONE    = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREG-1:0] NO_R0  = {{(NREG-1){1'b1}}, 1'b0};

  logic [OPC_W-1:0] opc;
  logic [2:0]       top3;
  logic [RA_W-1:0]  fa, fb, fc;
  logic [RA_W-1:0]  d_rs1, d_rs2, d_rd;
  logic             d_we, use1, use2;
  logic [1:0]       d_cls;

  assign opc  = in_instr[INSTR_W-1 -: OPC_W];
  assign top3 = opc[OPC_W-1 -: 3];
  assign fa   = in_instr[21 +: RA_W];
  assign fb   = in_instr[16 +: RA_W];
  assign fc   = in_instr[11 +: RA_W];

  always_comb begin
    d_rs1 = '0;
    d_rs2 = '0;
    d_rd  = '0;
    d_we  = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    d_cls = 2'd0;
    if (top3[2:1] == 2'b01) begin
      d_rs1 = fb; d_rs2 = fc; d_rd = fa; d_we = 1'b1;
      use1 = 1'b1; use2 = 1'b1; d_cls = 2'd0;
    end else if (top3[2:1] == 2'b10) begin
      d_rs1 = fa; d_rs2 = fb;
      use1 = 1'b1; use2 = 1'b1; d_cls = 2'd1;
    end else if (top3 == 3'b110) begin
      d_rs1 = fb; d_rd = fa; d_we = 1'b1;
      use1 = 1'b1; d_cls = 2'd2;
    end else if (top3 == 3'b111) begin
      d_cls = 2'd3;
      d_rs1 = fb;
      use1  = 1'b1;
      if (opc[0]) begin
        d_rs2 = fa; use2 = 1'b1;
      end else begin
        d_rd = fa; d_we = 1'b1;
      end
    end
  end

  // A same-cycle writeback releases its register before the hazard check.
  logic [NREG-1:0] wb_mask, busy_eff, set_mask;
  logic            hz1, hz2, hzd, hazard, accept, issue;

  assign wb_mask  = wb_valid ? (ONE << wb_addr) : '0;
  assign busy_eff = busy_vec & ~wb_mask;

  assign hz1 = use1 && (d_rs1 != '0) &&
               (busy_eff[d_rs1] || (out_valid && out_rd_we && out_rd == d_rs1));
  assign hz2 = use2 && (d_rs2 != '0) &&
               (busy_eff[d_rs2] || (out_valid && out_rd_we && out_rd == d_rs2));
  assign hzd = d_we && (d_rd != '0) &&
               (busy_eff[d_rd] || (out_valid && out_rd_we && out_rd == d_rd));
  assign hazard = hz1 | hz2 | hzd;

  assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready & ~flush;
  assign set_mask = (issue && out_rd_we && out_rd != '0) ? (ONE << out_rd) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_rsel1 <= '0;
      out_rsel2 <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
      out_class <= 2'd0;
      busy_vec  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= in_instr;
        out_rsel1 <= d_rs1;
        out_rsel2 <= d_rs2;
        out_rd    <= d_rd;
        out_rd_we <= d_we;
        out_class <= d_cls;
      end else if (flush || issue) begin
        out_valid <= 1'b0;
      end
      busy_vec <= ((busy_vec & ~wb_mask) | set_mask) & NO_R0;
      if (in_valid && hazard && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regsel_issue_stage.sv
// tb/tb_regsel_issue_stage.sv - scoreboard bench for regsel_issue_stage
module tb_regsel_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [4:0]  out_rsel1, out_rsel2, out_rd, wb_addr;
  logic        out_rd_we, wb_valid;
  logic [1:0]  out_class;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [49:0] exp_q[$];

  regsel_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_rsel1(out_rsel1),
    .out_rsel2(out_rsel2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_class(out_class), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] a, b, c);
    return {o, a, b, c, 11'd0};
  endfunction

  function automatic logic [49:0] ev(input logic [31:0] i, input logic [4:0] r1, r2, rd,
                                     input logic we, input logic [1:0] cls);
    return {i, r1, r2, rd, we, cls};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 64'(out_instr), 64'hdead);
      else chk("issue_fields", 64'({out_instr, out_rsel1, out_rsel2, out_rd, out_rd_we, out_class}),
               64'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [31:0] instr, input logic [49:0] exp, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] i_r, i_br, i_ia, i_r4, i_st, i_ld, i_nop, i_ia5;
  logic [49:0] e_br;

  initial begin
    i_r   = mk(6'b010010, 5'd3, 5'd0, 5'd1);
    i_br  = mk(6'b100000, 5'd1, 5'd2, 5'd0);
    i_ia  = mk(6'b110011, 5'd1, 5'd2, 5'd0);
    i_r4  = mk(6'b010000, 5'd4, 5'd1, 5'd0);
    i_st  = mk(6'b111011, 5'd1, 5'd2, 5'd0);
    i_ld  = mk(6'b111010, 5'd1, 5'd2, 5'd0);
    i_nop = mk(6'b000101, 5'd7, 5'd8, 5'd9);
    i_ia5 = mk(6'b110000, 5'd5, 5'd0, 5'd0);
    e_br  = ev(i_br, 5'd1, 5'd2, 5'd0, 1'b0, 2'd1);

    rst_n = 1'b0; in_valid = 1'b1; in_instr = i_r; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_fields", 64'({out_instr, out_rsel1, out_rsel2, out_rd, out_rd_we, out_class}), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    send(i_r, ev(i_r, 5'd0, 5'd1, 5'd3, 1'b1, 2'd0), 1'b1);
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r_issue_busy3", 64'(busy_vec), 64'h8);
    chk("r_valid_drop", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_addr = 5'd3;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("wb_clear3", 64'(busy_vec), 64'h0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(i_br, e_br, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_fields", 64'({out_instr, out_rsel1, out_rsel2, out_rd, out_rd_we, out_class}), 64'(e_br));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send(i_ia, ev(i_ia, 5'd2, 5'd0, 5'd1, 1'b1, 2'd2), 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ialu_busy1", 64'(busy_vec), 64'h2);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = i_r4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("raw_in_ready", 64'(in_ready), 64'd0);
      chk("raw_stall_cnt", 64'(stall_cnt), 64'(k));
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_addr = 5'd1;
    @(negedge clk);
    chk("wb_bypass_ready", 64'(in_ready), 64'd1);
    chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
    exp_q.push_back(ev(i_r4, 5'd1, 5'd0, 5'd4, 1'b1, 2'd0));
    @(posedge clk); #1;
    in_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("wb_bypass_busy", 64'(busy_vec), 64'h0);
    @(posedge clk); #1;

    send(i_st, ev(i_st, 5'd2, 5'd1, 5'd0, 1'b0, 2'd3), 1'b1);
    send(i_ld, ev(i_ld, 5'd2, 5'd0, 5'd1, 1'b1, 2'd3), 1'b1);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_addr = 5'd4;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("mem_busy", 64'(busy_vec), 64'h2);
    chk("stall_hold", 64'(stall_cnt), 64'd3);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(i_nop, '0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy_vec), 64'h2);

    @(posedge clk); #1;
    send(i_ia5, ev(i_ia5, 5'd0, 5'd0, 5'd5, 1'b1, 2'd2), 1'b1);
    out_ready = 1'b1; wb_valid = 1'b1; wb_addr = 5'd5;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("set_wins", 64'(busy_vec), 64'h22);

    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = i_ia5;
    @(negedge clk);
    chk("waw_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("waw_stall", 64'(stall_cnt), 64'd4);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(i_nop, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_busy", 64'(busy_vec), 64'd0);
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
